// File: rtl/setup_pkg.sv
// Shared constants and state encoding for the ORAM input-loading front end.
// The helper clamps the host-supplied input count to the buffer capacity.
package setup_pkg;

  localparam int DataWidth        = 128;
  localparam int SetupStatesWidth = 2;
  localparam int MaxInputLength   = 16;
  localparam int IdxWidth         = $clog2(MaxInputLength);
  localparam int LenWidth         = IdxWidth + 1;

  typedef enum logic [SetupStatesWidth-1:0] {
    ST_HEADER           = 2'd0,
    ST_INPUT_ENCRYPTION = 2'd1,
    ST_EXECUTE          = 2'd2
  } setup_state_e;

  function automatic logic [LenWidth-1:0] clamp_len(input logic [7:0] raw);
    if (raw > 8'(MaxInputLength)) begin
      return LenWidth'(MaxInputLength);
    end
    return raw[LenWidth-1:0];
  endfunction

endpackage

// File: rtl/setup.sv
// Host handshake FSM that fetches the input count and input words, masks
// words 1..L-1 with word 0 as key, and parks in execute once loading is done.
//
// state               | meaning
// --------------------+---------------------------------------------------
// ST_HEADER           | requesting input count L (DataOut = 0)
// ST_INPUT_ENCRYPTION | requesting word idx, storing it (masked if idx > 0)
// ST_EXECUTE          | loading done, downstream may run; terminal
module setup
  import setup_pkg::*;
(
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [DataWidth-1:0]        DataIn,
  input  logic                        DataInValid,
  output logic [DataWidth-1:0]        DataOut,
  output logic                        DataOutValid,
  output logic [SetupStatesWidth-1:0] Cmd
);

  setup_state_e         state_q, state_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [IdxWidth-1:0]  idx_q, idx_d;
  logic [DataWidth-1:0] key_q, key_d;
  logic [DataWidth-1:0] data_out_q, data_out_d;
  logic                 data_out_valid_q, data_out_valid_d;

  logic [DataWidth-1:0] mem_q [MaxInputLength];
  logic                 mem_we;
  logic [DataWidth-1:0] mem_wdata;
  logic                 accept;

  // A word is only taken while a request is actually visible to the host.
  assign accept = DataInValid & data_out_valid_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    key_d     = key_q;
    mem_we    = 1'b0;
    mem_wdata = DataIn;

    case (state_q)
      ST_HEADER: begin
        if (accept) begin
          len_d   = clamp_len(DataIn[7:0]);
          idx_d   = '0;
          state_d = (len_d == '0) ? ST_EXECUTE : ST_INPUT_ENCRYPTION;
        end
      end
      ST_INPUT_ENCRYPTION: begin
        if (accept) begin
          mem_we = 1'b1;
          if (idx_q == '0) begin
            key_d     = DataIn;
            mem_wdata = DataIn;
          end else begin
            mem_wdata = DataIn ^ key_q;
          end
          if ({1'b0, idx_q} == len_q - LenWidth'(1)) begin
            state_d = ST_EXECUTE;
          end else begin
            idx_d = idx_q + IdxWidth'(1);
          end
        end
      end
      ST_EXECUTE: begin
      end
      default: begin
        state_d = ST_HEADER;
        idx_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they track it with no lag.
    data_out_valid_d = (state_d != ST_EXECUTE);
    data_out_d       = (state_d == ST_INPUT_ENCRYPTION) ? DataWidth'(idx_d) : '0;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q          <= ST_HEADER;
      len_q            <= '0;
      idx_q            <= '0;
      key_q            <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      idx_q            <= idx_d;
      key_q            <= key_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
    end
  end

  // Buffer contents survive reset; only writes are blocked while it is held.
  always_ff @(posedge Clock) begin
    if (Reset && mem_we) begin
      mem_q[idx_q] <= mem_wdata;
    end
  end

  assign DataOut      = data_out_q;
  assign DataOutValid = data_out_valid_q;
  assign Cmd          = state_q;

endmodule

// File: tb/tb_setup.sv
// Directed bench for setup: a handshake-count model checked every cycle,
// plus literal expectations for requests, buffer contents and latency.
`timescale 1ns/1ps

module clock_source #(
  parameter real Freq = 1e9
) (
  input  logic Enable,
  output logic Clock
);
  localparam real HalfPeriodNs = 0.5e9 / Freq;

  initial Clock = 1'b0;

  always begin
    #(HalfPeriodNs);
    if (Enable) Clock = ~Clock;
  end
endmodule

module tb_setup;
  import setup_pkg::*;

  logic           clk_en;
  logic           clk;
  logic           rst;
  logic [127:0]   din;
  logic           din_valid;
  logic [127:0]   dout;
  logic           dout_valid;
  logic [1:0]     cmd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  clock_source #(.Freq(1e8)) u_clk (.Enable(clk_en), .Clock(clk));

  setup dut (
    .Clock        (clk),
    .Reset        (rst),
    .DataIn       (din),
    .DataInValid  (din_valid),
    .DataOut      (dout),
    .DataOutValid (dout_valid),
    .Cmd          (cmd)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: everything follows from how many handshakes were accepted since
  // the FSM last left reset (first one carries L, the rest carry words).
  bit           m_started = 0;
  bit           chk_en    = 0;
  int           m_cnt     = 0;
  int           m_len     = 0;
  int           w;
  bit           m_exec;
  logic [127:0] m_key;
  logic [127:0] m_mem [16];
  bit           m_written [16];
  int           e_cmd;
  int           e_dout;
  bit           e_dov;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_started = 0;
      m_cnt     = 0;
      m_len     = 0;
      m_key     = '0;
      chk_en    = 1;
    end else begin
      m_exec = (m_cnt >= 1) && (m_cnt > m_len);
      if (din_valid && m_started && !m_exec) begin
        if (m_cnt == 0) begin
          m_len = (int'(din[7:0]) > 16) ? 16 : int'(din[7:0]);
        end else begin
          w = m_cnt - 1;
          if (w == 0) begin
            m_key    = din;
            m_mem[0] = din;
          end else begin
            m_mem[w] = din ^ m_key;
          end
          m_written[w] = 1;
        end
        m_cnt++;
      end
      m_started = 1;
    end
    #1;
    if (chk_en) begin
      m_exec = (m_cnt >= 1) && (m_cnt > m_len);
      e_dov  = m_started && !m_exec;
      e_cmd  = (m_cnt == 0) ? 0 : (m_exec ? 2 : 1);
      e_dout = (e_cmd == 1) ? m_cnt - 1 : 0;
      check("model_cmd", cmd, e_cmd);
      check("model_dov", dout_valid, e_dov);
      check("model_dout", dout, e_dout);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst       = 0;
    din_valid = 0;
    repeat (2) @(negedge clk);
    check("reset_cmd", cmd, 0);
    check("reset_dov", dout_valid, 0);
    check("reset_dout", dout, 0);
    rst = 1;
  endtask

  task automatic hs(input logic [127:0] d, input int exp_idx, input string nm);
    @(negedge clk);
    check(nm, dout, exp_idx);
    check({nm, "_valid"}, dout_valid, 1);
    din       = d;
    din_valid = 1;
  endtask

  task automatic mem_check();
    for (int i = 0; i < 16; i++) begin
      if (m_written[i]) check($sformatf("mem%0d", i), dut.mem_q[i], m_mem[i]);
    end
  endtask

  localparam logic [127:0] W0 = 128'h00112233_44556677_8899aabb_ccddeeff;

  initial begin
    int c0;
    clk_en    = 1;
    rst       = 0;
    din       = '0;
    din_valid = 0;

    // Nominal L=3 run
    do_reset();
    hs(128'd3, 0, "nom_hdr");
    c0 = cyc;
    hs(W0, 0, "nom_req0");
    hs(128'h1, 1, "nom_req1");
    hs(128'd19, 2, "nom_req2");
    @(negedge clk);
    din_valid = 0;
    check("nom_exec", cmd, 2);
    check("nom_exec_dov", dout_valid, 0);
    check("nom_latency", 128'(cyc - c0), 4);
    check("nom_mem0", dut.mem_q[0], W0);
    check("nom_mem1", dut.mem_q[1], 128'h00112233_44556677_8899aabb_ccddeefe);
    check("nom_mem2", dut.mem_q[2], 128'h00112233_44556677_8899aabb_ccddeeec);
    check("model_mem1", m_mem[1], 128'h00112233_44556677_8899aabb_ccddeefe);
    check("model_mem2", m_mem[2], 128'h00112233_44556677_8899aabb_ccddeeec);

    // Stall at idx=1
    do_reset();
    hs(128'd3, 0, "stall_hdr");
    hs(128'hdead_beef_0000_1111, 0, "stall_req0");
    repeat (5) begin
      @(negedge clk);
      din_valid = 0;
      check("stall_dout", dout, 1);
      check("stall_dov", dout_valid, 1);
    end
    hs(128'h55, 1, "stall_req1");
    hs(128'haa, 2, "stall_req2");
    @(negedge clk);
    din_valid = 0;
    check("stall_exec", cmd, 2);
    check("stall_mem1", dut.mem_q[1], 128'hdead_beef_0000_1111 ^ 128'h55);

    // L=0 goes straight to execute
    do_reset();
    hs(128'd0, 0, "l0_hdr");
    @(negedge clk);
    din_valid = 0;
    check("l0_exec", cmd, 2);
    check("l0_dov", dout_valid, 0);

    // Oversized L clamps to 16 words; upper DataIn bits are not part of L
    do_reset();
    hs({120'hab, 8'd21}, 0, "big_hdr");
    for (int i = 0; i < 16; i++) begin
      hs(128'(32'h0101_0101 * i + 7), i, $sformatf("big_req%0d", i));
    end
    @(negedge clk);
    din_valid = 0;
    check("big_exec", cmd, 2);
    mem_check();

    // Reset mid-load, then a fresh L=2 run
    do_reset();
    hs(128'd3, 0, "mid_hdr");
    hs(128'h1234, 0, "mid_req0");
    @(negedge clk);
    rst       = 0;
    din       = 128'hffff;
    din_valid = 1;
    @(negedge clk);
    check("mid_rst_cmd", cmd, 0);
    check("mid_rst_dov", dout_valid, 0);
    @(negedge clk);
    rst = 1;
    din = 128'd5;
    hs(128'd2, 0, "mid2_hdr");
    hs(128'h77, 0, "mid2_req0");
    hs(128'h70, 1, "mid2_req1");
    @(negedge clk);
    din_valid = 0;
    check("mid2_exec", cmd, 2);
    check("mid2_mem1", dut.mem_q[1], 128'h07);

    // Pulses in execute are ignored
    repeat (4) begin
      @(negedge clk);
      din       = 128'hbad0_0000 + 128'(cyc);
      din_valid = 1;
    end
    @(negedge clk);
    din_valid = 0;
    check("exec_hold_cmd", cmd, 2);
    check("exec_hold_mem0", dut.mem_q[0], 128'h77);
    mem_check();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
